// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: mode encoding, BCD digit width,
// adjust-field codes and helpers that split a decimal limit into BCD digits.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSE  = 2'b01,
        ST_ADJUST = 2'b10
    } sw_state_e;

    localparam logic [1:0] ADJ_NONE = 2'b00;
    localparam logic [1:0] ADJ_MIN  = 2'b10;
    localparam logic [1:0] ADJ_SEC  = 2'b01;

    function automatic logic [DIGIT_W-1:0] tens_of(input int value);
        return DIGIT_W'((value / 10) % 10);
    endfunction

    function automatic logic [DIGIT_W-1:0] ones_of(input int value);
        return DIGIT_W'(value % 10);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that increments on inc and wraps to 00 after MAX.
import stopwatch_pkg::*;

module bcd2_counter #(
    parameter int MAX = 59
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               at_max
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = tens_of(MAX);
    localparam logic [DIGIT_W-1:0] MAX_ONES = ones_of(MAX);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               at_max_s;

    assign at_max_s = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    // Next digit values: wrap at the field limit, otherwise BCD increment with carry.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max_s) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                if (tens_q == 4'd9) begin
                    tens_d = 4'd0;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else begin
            tens_d = tens_q;
            ones_d = ones_q;
        end
    end

    // Digit registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens   = tens_q;
    assign ones   = ones_q;
    assign at_max = at_max_s;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/pause/adjust modes; the 1 Hz and 2 Hz ticks are
// used purely as clock enables on sys_clk.
import stopwatch_pkg::*;

module stopwatch_counter #(
    parameter int MIN_MAX = 99,
    parameter int SEC_MAX = 59
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               onehz_tick,
    input  logic               twohz_tick,
    input  logic               pause_pulse,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic [1:0]         adj_field,
    output logic               wrap
);

    sw_state_e  state_q, state_d;
    logic       resume_q, resume_d;
    logic       running_q, running_d;
    logic [1:0] adj_field_q, adj_field_d;
    logic       wrap_q, wrap_d;
    logic       sec_inc_s, min_inc_s;
    logic       sec_at_max_s, min_at_max_s;
    logic       run_tick_s, adj_tick_s;

    // State and resume-flag registers; resume=1 means leave ADJUST into RUN.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            resume_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // Mode transitions; adj takes priority over pause_pulse outside ADJUST.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        case (state_q)
            ST_RUN: begin
                if (adj) begin
                    state_d  = ST_ADJUST;
                    resume_d = 1'b1;
                end else if (pause_pulse) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (adj) begin
                    state_d  = ST_ADJUST;
                    resume_d = 1'b0;
                end else if (pause_pulse) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_ADJUST: begin
                resume_d = resume_q ^ pause_pulse;
                if (!adj) begin
                    state_d = resume_d ? ST_RUN : ST_PAUSE;
                end else begin
                    state_d = ST_ADJUST;
                end
            end
            default: begin
                state_d  = ST_RUN;
                resume_d = 1'b1;
            end
        endcase
    end

    // Counter enables and next values of the registered status outputs.
    always_comb begin
        run_tick_s  = (state_q == ST_RUN) && onehz_tick;
        adj_tick_s  = (state_q == ST_ADJUST) && twohz_tick;
        sec_inc_s   = run_tick_s || (adj_tick_s && sel);
        min_inc_s   = (run_tick_s && sec_at_max_s) || (adj_tick_s && !sel);
        wrap_d      = run_tick_s && sec_at_max_s && min_at_max_s;
        running_d   = (state_d == ST_RUN);
        adj_field_d = ADJ_NONE;
        if (state_d == ST_ADJUST) begin
            adj_field_d = sel ? ADJ_SEC : ADJ_MIN;
        end else begin
            adj_field_d = ADJ_NONE;
        end
    end

    // Registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            running_q   <= 1'b1;
            adj_field_q <= ADJ_NONE;
            wrap_q      <= 1'b0;
        end else begin
            running_q   <= running_d;
            adj_field_q <= adj_field_d;
            wrap_q      <= wrap_d;
        end
    end

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .sys_clk (sys_clk),
        .rst     (rst),
        .inc     (sec_inc_s),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .at_max  (sec_at_max_s)
    );

    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .sys_clk (sys_clk),
        .rst     (rst),
        .inc     (min_inc_s),
        .tens    (min_tens),
        .ones    (min_ones),
        .at_max  (min_at_max_s)
    );

    assign running   = running_q;
    assign adj_field = adj_field_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus random
// stimulus compared against an integer minutes/seconds reference model.
module tb_stopwatch_counter;

    localparam int MIN_MAX = 99;
    localparam int SEC_MAX = 59;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       onehz_tick = 1'b0;
    logic       twohz_tick = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [1:0] adj_field;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = RUN, 1 = PAUSE, 2 = ADJUST
    int         m_min, m_sec, m_state;
    logic       m_resume;
    logic       m_wrap;
    logic [1:0] m_adjf;

    logic [22:0] dut_vec;
    assign dut_vec = {min_tens, min_ones, sec_tens, sec_ones, running, adj_field, wrap};

    stopwatch_counter #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .onehz_tick  (onehz_tick),
        .twohz_tick  (twohz_tick),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .adj_field   (adj_field),
        .wrap        (wrap)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [22:0] exp_vec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                (m_state == 0) ? 1'b1 : 1'b0, m_adjf, m_wrap};
    endfunction

    function automatic void model_update(input logic r, o, t, p, a, s);
        int ns;
        if (r) begin
            m_min = 0; m_sec = 0; m_state = 0; m_resume = 1'b1;
            m_wrap = 1'b0; m_adjf = 2'b00;
            return;
        end
        m_wrap = 1'b0;
        if (m_state == 0 && o) begin
            if (m_sec == SEC_MAX) begin
                m_sec = 0;
                if (m_min == MIN_MAX) begin
                    m_min = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_min = m_min + 1;
                end
            end else begin
                m_sec = m_sec + 1;
            end
        end else if (m_state == 2 && t) begin
            if (s) m_sec = (m_sec + 1) % (SEC_MAX + 1);
            else   m_min = (m_min + 1) % (MIN_MAX + 1);
        end
        ns = m_state;
        if (m_state == 0) begin
            if (a) begin ns = 2; m_resume = 1'b1; end
            else if (p) ns = 1;
        end else if (m_state == 1) begin
            if (a) begin ns = 2; m_resume = 1'b0; end
            else if (p) ns = 0;
        end else begin
            if (p) m_resume = ~m_resume;
            if (!a) ns = m_resume ? 0 : 1;
        end
        m_state = ns;
        m_adjf  = (ns == 2) ? (s ? 2'b01 : 2'b10) : 2'b00;
    endfunction

    task automatic step(input logic r, o, t, p, a, s);
        rst = r; onehz_tick = o; twohz_tick = t; pause_pulse = p; adj = a; sel = s;
        @(posedge sys_clk);
        model_update(r, o, t, p, a, s);
        #1;
        rst = 1'b0; onehz_tick = 1'b0; twohz_tick = 1'b0; pause_pulse = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut_vec !== {16'h0000, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", dut_vec, {16'h0000, 1'b1, 2'b00, 1'b0});
        end
    endtask

    task automatic test_count_61();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) begin
            step(0, 1, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1));
            n_checks++;
            if (wrap !== 1'b0 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL count61 tick %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(0, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, running} !== {16'h0101, 1'b1}) begin
            n_fail++;
            $display("FAIL count61 final: got %h expected %h",
                     {min_tens, min_ones, sec_tens, sec_ones, running}, {16'h0101, 1'b1});
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 99; i++) step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, running} !== {16'h9958, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap preload: got %h expected %h",
                     {min_tens, min_ones, sec_tens, sec_ones, running}, {16'h9958, 1'b1});
        end
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap} !== {16'h9959, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap first tick: got %h expected %h",
                     {min_tens, min_ones, sec_tens, sec_ones, wrap}, {16'h9959, 1'b0});
        end
        step(0, 1, 0, 0, 0, 0);
        n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap} !== {16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap second tick: got %h expected %h",
                     {min_tens, min_ones, sec_tens, sec_ones, wrap}, {16'h0000, 1'b1});
        end
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap one-cycle: got %b expected 0", wrap);
        end
    endtask

    task automatic test_pause_coincident();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h06, 1'b0}) begin
            n_fail++;
            $display("FAIL pause coincident: got %h expected %h",
                     {sec_tens, sec_ones, running}, {8'h06, 1'b0});
        end
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        n_checks++;
        if (dut_vec !== {16'h0006, 1'b0, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL pause hold: got %h expected %h", dut_vec, {16'h0006, 1'b0, 2'b00, 1'b0});
        end
        step(0, 0, 0, 1, 0, 0);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL pause resume: got %b expected 1", running);
        end
    endtask

    task automatic test_adjust_sec();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 1);
        n_checks++;
        if (dut_vec !== {16'h0001, 1'b0, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL adjust seconds: got %h expected %h", dut_vec, {16'h0001, 1'b0, 2'b01, 1'b0});
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_adjust_min_from_pause();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 1, 0);
        n_checks++;
        if (dut_vec !== {16'h0000, 1'b0, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL adjust minutes wrap: got %h expected %h", dut_vec, {16'h0000, 1'b0, 2'b10, 1'b0});
        end
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut_vec !== {16'h0100, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL adjust exit to run: got %h expected %h", dut_vec, {16'h0100, 1'b1, 2'b00, 1'b0});
        end
    endtask

    task automatic test_rst_mid_adjust();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 1, 1);
        n_checks++;
        if (dut_vec !== {16'h1234, 1'b0, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL preload 12:34: got %h expected %h", dut_vec, {16'h1234, 1'b0, 2'b01, 1'b0});
        end
        step(1, 0, 1, 0, 1, 1);
        n_checks++;
        if (dut_vec !== {16'h0000, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset mid-adjust: got %h expected %h", dut_vec, {16'h0000, 1'b1, 2'b00, 1'b0});
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic a_lvl, s_lvl;
        a_lvl = 1'b0;
        s_lvl = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) a_lvl = ~a_lvl;
            if ($urandom_range(0, 19) == 0) s_lvl = ~s_lvl;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0), a_lvl, s_lvl);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        m_min = 0; m_sec = 0; m_state = 0; m_resume = 1'b1; m_wrap = 1'b0; m_adjf = 2'b00;
        #2;
        test_reset();
        test_count_61();
        test_wrap();
        test_pause_coincident();
        test_adjust_sec();
        test_adjust_min_from_pause();
        test_rst_mid_adjust();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
